// File: rtl/decoder_3_to_8_pulse_if.sv
// Valid/ready code input and timed one-hot output bundle for decoder_3_to_8_pulse.
// The master side supplies codes; the slave side is the decoder.
interface decoder_3_to_8_pulse_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic [7:0] out;
  logic       busy;
  logic       last;

  modport master (
    output in_valid,
    output in_code,
    input  in_ready,
    input  out,
    input  busy,
    input  last
  );

  modport slave (
    input  in_valid,
    input  in_code,
    output in_ready,
    output out,
    output busy,
    output last
  );
endinterface

// File: rtl/decoder_3_to_8_pulse.sv
// Sequential 3-to-8 decoder: each accepted code drives its one-hot line for HOLD_CYCLES cycles.
// Define DECODER_SKID_EN to add a one-entry pending buffer for back-to-back holds.
module decoder_3_to_8_pulse #(
  parameter int unsigned  HOLD_CYCLES = 4,
  localparam int unsigned CNT_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input logic                   clk,
  input logic                   rst_n,
  decoder_3_to_8_pulse_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       out_q, out_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;
  logic             in_ready;
  logic             accept;
  logic             load_new;
  logic [2:0]       load_code;

`ifdef DECODER_SKID_EN
  logic       pend_valid_q, pend_valid_d;
  logic [2:0] pend_code_q, pend_code_d;

  assign in_ready = (state_q == StIdle) || !pend_valid_q;
`else
  assign in_ready = (state_q == StIdle);
`endif

  assign accept = bus.in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    load_new  = 1'b0;
    load_code = bus.in_code;
`ifdef DECODER_SKID_EN
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          load_new = 1'b1;
        end
      end
      StHold: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
`ifdef DECODER_SKID_EN
          if (accept) begin
            pend_valid_d = 1'b1;
            pend_code_d  = bus.in_code;
          end
`endif
        end else begin
`ifdef DECODER_SKID_EN
          // Final cycle: a buffered code wins; otherwise a fresh code bypasses the buffer.
          if (pend_valid_q) begin
            load_new     = 1'b1;
            load_code    = pend_code_q;
            pend_valid_d = 1'b0;
          end else if (accept) begin
            load_new = 1'b1;
          end else begin
            state_d = StIdle;
            out_d   = 8'h00;
          end
`else
          state_d = StIdle;
          out_d   = 8'h00;
`endif
        end
      end
      default: begin
        state_d = StIdle;
        out_d   = 8'h00;
      end
    endcase

    if (load_new) begin
      state_d = StHold;
      cnt_d   = CntLoad;
      out_d   = 8'h01 << load_code;
    end

    busy_d = (state_d == StHold);
    last_d = (state_d == StHold) && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      out_q   <= 8'h00;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
`ifdef DECODER_SKID_EN
      pend_valid_q <= 1'b0;
      pend_code_q  <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
`ifdef DECODER_SKID_EN
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
`endif
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.out      = out_q;
  assign bus.busy     = busy_q;
  assign bus.last     = last_q;

endmodule
